// File: rtl/ahb_split_mask_ctrl.sv
// Masks bus requests of AHB masters that received a SPLIT response until the
// slave releases them through hsplitx or a per-master watchdog expires.
module ahb_split_mask_ctrl #(
  parameter int unsigned NUM_MASTERS = 5,
  parameter int unsigned MIDX_W      = 3,
  parameter int unsigned DEF_MASTER  = 0,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned TIMEOUT     = 200
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  input  logic [MIDX_W-1:0]      hmaster,
  input  logic [NUM_MASTERS-1:0] hsplitx,
  input  logic [NUM_MASTERS-1:0] hbusreqx,
  output logic [NUM_MASTERS-1:0] hbusreq_masked,
  output logic [NUM_MASTERS-1:0] split_mask,
  output logic                   tmo_pulse,
  output logic [NUM_MASTERS-1:0] tmo_vec,
  output logic                   proto_err
);

  if (TIMEOUT == 0 || TIMEOUT > (2 ** TMO_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..2^TMO_W-1");
  end

  typedef enum logic {
    IDLE,
    SPL1
  } state_e;

  localparam logic [1:0] RESP_SPLIT = 2'b11;

  state_e                 state_q;
  logic [MIDX_W-1:0]      dmaster_q;
  logic [NUM_MASTERS-1:0] mask_q;
  logic [NUM_MASTERS-1:0] mask_d;
  logic [NUM_MASTERS-1:0] set_d;
  logic [NUM_MASTERS-1:0] expire_d;
  logic [NUM_MASTERS-1:0] tmo_vec_q;
  logic                   tmo_pulse_q;
  logic                   proto_err_q;
  logic [TMO_W-1:0]       cnt_q [NUM_MASTERS];

  logic resp_split;
  logic split_done;
  logic def_done;

  assign resp_split = (hresp == RESP_SPLIT);
  assign split_done = (state_q == SPL1) && resp_split && hready;
  assign def_done   = split_done && (dmaster_q == MIDX_W'(DEF_MASTER));

  // Release by hsplitx dominates both a new set and a watchdog expiry;
  // a fresh set on an already-masked master restarts its watchdog.
  always_comb begin
    set_d    = '0;
    expire_d = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      set_d[i]    = split_done && !def_done && (dmaster_q == MIDX_W'(i));
      expire_d[i] = mask_q[i] && (cnt_q[i] == TMO_W'(TIMEOUT - 1)) &&
                    !hsplitx[i] && !set_d[i];
    end
    mask_d = (mask_q | set_d) & ~hsplitx & ~expire_d;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= IDLE;
      dmaster_q   <= MIDX_W'(DEF_MASTER);
      mask_q      <= '0;
      tmo_vec_q   <= '0;
      tmo_pulse_q <= 1'b0;
      proto_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      if (hready) begin
        dmaster_q <= hmaster;
      end
      mask_q      <= mask_d;
      tmo_vec_q   <= expire_d;
      tmo_pulse_q <= |expire_d;
      proto_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (resp_split) begin
            if (hready) begin
              proto_err_q <= 1'b1;
            end else begin
              state_q <= SPL1;
            end
          end
        end
        SPL1: begin
          if (!resp_split) begin
            state_q     <= IDLE;
            proto_err_q <= 1'b1;
          end else if (hready) begin
            state_q <= IDLE;
            if (def_done) begin
              proto_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (set_d[i] || !mask_d[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + TMO_W'(1);
        end
      end
    end
  end

  assign split_mask     = mask_q;
  assign tmo_vec        = tmo_vec_q;
  assign tmo_pulse      = tmo_pulse_q;
  assign proto_err      = proto_err_q;
  assign hbusreq_masked = hbusreqx & ~mask_q;

endmodule
